// File: rtl/alu_mul_ctrl.sv
// Shift-add 32x32->64 multiplier that borrows the execute-stage ALU as its adder; signed mode under `ALU_MUL_SIGNED_EN`.
// Latency: resp_valid 32 edges after accept (36 for signed requests).
// Backpressure: one op in flight, req_ready low until the response handshake; response held stable while resp_ready=0.
module alu_mul_ctrl #(
    parameter logic [3:0] ALU_ADD  = 4'b0010,
    parameter logic [3:0] ALU_SUB  = 4'b0110,
    parameter logic [3:0] ALU_NOR  = 4'b1100,
    parameter logic [3:0] ALU_IDLE = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
`ifdef ALU_MUL_SIGNED_EN
    input  logic        req_signed,
`endif
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_hi,
    output logic [31:0] resp_lo,
    output logic        resp_ovf,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic        alu_cout
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        DONE   = 3'd2
`ifdef ALU_MUL_SIGNED_EN
        ,
        ABS_A  = 3'd3,
        ABS_B  = 3'd4,
        NEG_LO = 3'd5,
        NEG_HI = 3'd6
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] m_q, m_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_hi_q, resp_hi_d;
    logic [31:0] resp_lo_q, resp_lo_d;
    logic        resp_ovf_q, resp_ovf_d;
    logic        sgn_q, sgn_d;
`ifdef ALU_MUL_SIGNED_EN
    logic        neg_q, neg_d;
    logic        c_q, c_d;
`endif

    always_comb begin
        state_d      = state_q;
        m_d          = m_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_hi_d    = resp_hi_q;
        resp_lo_d    = resp_lo_q;
        resp_ovf_d   = resp_ovf_q;
        sgn_d        = sgn_q;
`ifdef ALU_MUL_SIGNED_EN
        neg_d        = neg_q;
        c_d          = c_q;
`endif
        alu_src1     = 32'd0;
        alu_src2     = 32'd0;
        alu_ctrl     = ALU_IDLE;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    m_d         = req_a;
                    lo_d        = req_b;
                    hi_d        = 32'd0;
                    cnt_d       = 6'd0;
                    req_ready_d = 1'b0;
`ifdef ALU_MUL_SIGNED_EN
                    sgn_d   = req_signed;
                    neg_d   = req_signed & (req_a[31] ^ req_b[31]);
                    c_d     = 1'b0;
                    state_d = req_signed ? ABS_A : RUN;
`else
                    sgn_d   = 1'b0;
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                alu_src1 = hi_q;
                alu_src2 = lo_q[0] ? m_q : 32'd0;
                alu_ctrl = ALU_ADD;
                // Product shifts right through HI:LO; cout is bit 32 of the partial sum.
                hi_d  = {alu_cout, alu_result[31:1]};
                lo_d  = {alu_result[0], lo_q[31:1]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
`ifdef ALU_MUL_SIGNED_EN
                    state_d = sgn_q ? NEG_LO : DONE;
`else
                    state_d = DONE;
`endif
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_hi_d    = 32'd0;
                    resp_lo_d    = 32'd0;
                    resp_ovf_d   = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
`ifdef ALU_MUL_SIGNED_EN
            ABS_A: begin
                alu_src2 = m_q;
                alu_ctrl = ALU_SUB;
                if (m_q[31]) m_d = alu_result;
                state_d = ABS_B;
            end
            ABS_B: begin
                alu_src2 = lo_q;
                alu_ctrl = ALU_SUB;
                if (lo_q[31]) lo_d = alu_result;
                state_d = RUN;
            end
            NEG_LO: begin
                alu_src2 = lo_q;
                alu_ctrl = ALU_SUB;
                // 0-LO carries out only when LO==0, i.e. the +1 ripples into HI.
                if (neg_q) begin
                    lo_d = alu_result;
                    c_d  = alu_cout;
                end
                state_d = NEG_HI;
            end
            NEG_HI: begin
                if (c_q) begin
                    alu_src2 = hi_q;
                    alu_ctrl = ALU_SUB;
                end else begin
                    alu_src1 = hi_q;
                    alu_src2 = hi_q;
                    alu_ctrl = ALU_NOR;
                end
                if (neg_q) hi_d = alu_result;
                state_d = DONE;
            end
`endif
            default: state_d = IDLE;
        endcase

        if (state_d == DONE && state_q != DONE) begin
            resp_valid_d = 1'b1;
            resp_hi_d    = hi_d;
            resp_lo_d    = lo_d;
            resp_ovf_d   = sgn_q ? (hi_d != {32{lo_d[31]}}) : (hi_d != 32'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            m_q          <= 32'd0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            cnt_q        <= 6'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_hi_q    <= 32'd0;
            resp_lo_q    <= 32'd0;
            resp_ovf_q   <= 1'b0;
            sgn_q        <= 1'b0;
`ifdef ALU_MUL_SIGNED_EN
            neg_q        <= 1'b0;
            c_q          <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            m_q          <= m_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_hi_q    <= resp_hi_d;
            resp_lo_q    <= resp_lo_d;
            resp_ovf_q   <= resp_ovf_d;
            sgn_q        <= sgn_d;
`ifdef ALU_MUL_SIGNED_EN
            neg_q        <= neg_d;
            c_q          <= c_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_hi    = resp_hi_q;
    assign resp_lo    = resp_lo_q;
    assign resp_ovf   = resp_ovf_q;

endmodule

// File: tb/tb_alu_mul_ctrl.sv
// Scoreboard bench for alu_mul_ctrl with a behavioural ALU closing the src/ctrl -> result/cout loop.
module tb_alu_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a, req_b;
    logic        req_s;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_hi, resp_lo;
    logic        resp_ovf;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_cout;

    always #5 clk = ~clk;

    alu_mul_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
`ifdef ALU_MUL_SIGNED_EN
        .req_signed (req_s),
`endif
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hi    (resp_hi),
        .resp_lo    (resp_lo),
        .resp_ovf   (resp_ovf),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_cout   (alu_cout)
    );

    // ALU model: ctrl = {A_invert, B_invert(=cin), op[1:0]}; op 00 AND, 01 OR, 10 add.
    logic [31:0] alu_a, alu_b;
    logic [32:0] alu_sum;
    always_comb begin
        alu_a   = alu_ctrl[3] ? ~alu_src1 : alu_src1;
        alu_b   = alu_ctrl[2] ? ~alu_src2 : alu_src2;
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_ctrl[2]};
        case (alu_ctrl[1:0])
            2'b00:   alu_result = alu_a & alu_b;
            2'b01:   alu_result = alu_a | alu_b;
            default: alu_result = alu_sum[31:0];
        endcase
        alu_cout = alu_sum[32];
    end

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_resp", {63'd0, resp_valid}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("resp_hi", {32'd0, resp_hi}, {32'd0, e.hi});
                check("resp_lo", {32'd0, resp_lo}, {32'd0, e.lo});
                check("resp_ovf", {63'd0, resp_ovf}, {63'd0, e.ovf});
            end
        end
    end

    task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic sg,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic eovf,
                          input int lat);
        int w, cyc, adds;
        exp_t e;
        w = 0;
        while (req_ready !== 1'b1 && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        check("req_ready_before_req", {63'd0, req_ready}, 64'd1);
        e.hi = ehi; e.lo = elo; e.ovf = eovf;
        sb_q.push_back(e);
        req_a = a; req_b = b; req_s = sg; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 0; adds = 0;
        while (resp_valid !== 1'b1 && cyc < 200) begin
            if (alu_ctrl === 4'b0010) adds++;
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 64'(cyc), 64'(lat));
        check("run_add_cycles", 64'(adds), 64'd32);
        if (resp_ready) begin
            @(posedge clk); #1;
            check("idle_after_handshake", {62'd0, req_ready, resp_valid}, 64'b10);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_s = 1'b0; resp_ready = 1'b1;
        #12;
        check("reset_flags", {57'd0, req_ready, resp_valid, resp_ovf, alu_ctrl}, {57'd0, 7'b1000000});
        check("reset_resp", {resp_hi, resp_lo}, 64'd0);
        check("reset_alu_src", {alu_src1, alu_src2}, 64'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        do_req(32'd3, 32'd5, 1'b0, 32'd0, 32'd15, 1'b0, 32);
        do_req(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 1'b1, 32);
        do_req(32'h00010000, 32'h00010000, 1'b0, 32'd1, 32'd0, 1'b1, 32);
        do_req(32'h80000000, 32'd2, 1'b0, 32'd1, 32'd0, 1'b1, 32);

        // Backpressure: response held for 10 cycles, stray request ignored.
        resp_ready = 1'b0;
        do_req(32'h1234, 32'h10, 1'b0, 32'd0, 32'h12340, 1'b0, 32);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                req_a = 32'd99; req_b = 32'd99; req_valid = 1'b1;
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
            check("bp_hold", {resp_valid, req_ready, resp_ovf, resp_hi, 29'd0},
                  {1'b1, 1'b0, 1'b0, 32'd0, 29'd0});
            check("bp_lo_hold", {32'd0, resp_lo}, 64'h12340);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {62'd0, req_ready, resp_valid}, 64'b10);
        do_req(32'd11, 32'd13, 1'b0, 32'd0, 32'd143, 1'b0, 32);

        // Asynchronous reset mid-RUN aborts with no response.
        req_a = 32'h12345678; req_b = 32'd9; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (12) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_flags", {58'd0, req_ready, resp_valid, alu_ctrl}, {58'd0, 6'b100000});
        check("abort_resp", {resp_hi, resp_lo}, 64'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        do_req(32'd7, 32'd6, 1'b0, 32'd0, 32'd42, 1'b0, 32);

`ifdef ALU_MUL_SIGNED_EN
        do_req(32'hFFFFFFFD, 32'd7, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 36);
        do_req(32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'd0, 1'b1, 36);
        do_req(32'd0, 32'hFFFFFFFB, 1'b1, 32'd0, 32'd0, 1'b0, 36);
        do_req(32'hFFFFFFFD, 32'd7, 1'b0, 32'd6, 32'hFFFFFFEB, 1'b1, 32);
`endif

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
